// File: rtl/hamming_rx_stream.sv
// Purpose: serial Hamming(15,11) receiver; frames delimited by sof, single-bit errors corrected.
// Latency: the decoded word is valid in the second cycle after the cycle carrying the last bit.
// Backpressure: one-word output register; a completed frame is dropped with an overrun pulse if the word is unconsumed.
module hamming_rx_stream #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  input  logic                 sof,
  output logic [10:0]          data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 corrected,
  output logic [CNT_WIDTH-1:0] err_count,
  output logic                 overrun
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    DECODE = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] ERR_MAX = '1;

  // Receive side: frame state, number of positions stored, assembled codeword.
  // Position p of the codeword lives in cw_q[p-1].
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [14:0] cw_q, cw_d;

  // Output side: registered word, its qualifiers and the error counter.
  logic [10:0]          dout_q, dout_d;
  logic                 dvld_q, dvld_d;
  logic                 corr_q, corr_d;
  logic                 ovr_q, ovr_d;
  logic [CNT_WIDTH-1:0] errc_q, errc_d;

  // Decoder results, only meaningful while state_q == DECODE.
  logic [3:0]  syn;
  logic [14:0] fixed_cw;
  logic [10:0] dec_data;
  logic        load_word;

  // Syndrome is the XOR of the positions of all set bits; a nonzero value
  // names the single position to invert. Data sits at the non-power-of-two
  // positions 3,5,6,7,9..15.
  always_comb begin
    syn = 4'd0;
    for (int p = 1; p <= 15; p++) begin
      if (cw_q[p-1]) begin
        syn = syn ^ 4'(p);
      end
    end
    fixed_cw = cw_q;
    if (syn != 4'd0) begin
      fixed_cw[syn - 4'd1] = ~cw_q[syn - 4'd1];
    end
    dec_data = {fixed_cw[14:8], fixed_cw[6:4], fixed_cw[2]};
  end

  // Frame FSM next state: wait for sof, shift 15 positions, decode for one cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cw_d    = cw_q;
    unique case (state_q)
      IDLE: begin
        if (bit_valid && sof) begin
          cw_d    = {14'd0, bit_in};
          cnt_d   = 4'd1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_valid) begin
          if (sof) begin
            // Restart: partial frame is thrown away, this bit is position 1.
            cw_d  = {14'd0, bit_in};
            cnt_d = 4'd1;
          end else begin
            cw_d[cnt_q] = bit_in;
            if (cnt_q == 4'd14) begin
              cnt_d   = 4'd0;
              state_d = DECODE;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
        end
      end
      DECODE: begin
        // Input bits in this single cycle are ignored; next cycle accepts sof.
        cnt_d   = 4'd0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = 4'd0;
        state_d = IDLE;
      end
    endcase
  end

  // Output register: consume on handshake, load on DECODE exit when free
  // (or freed by the same-edge handshake), otherwise drop and flag overrun.
  always_comb begin
    dout_d    = dout_q;
    corr_d    = corr_q;
    dvld_d    = dvld_q;
    errc_d    = errc_q;
    ovr_d     = 1'b0;
    load_word = 1'b0;
    if (dvld_q && data_ready) begin
      dvld_d = 1'b0;
    end
    if (state_q == DECODE) begin
      if (!dvld_q || data_ready) begin
        load_word = 1'b1;
        dout_d    = dec_data;
        corr_d    = (syn != 4'd0);
        dvld_d    = 1'b1;
        if ((syn != 4'd0) && (errc_q != ERR_MAX)) begin
          errc_d = errc_q + 1'b1;
        end
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      cw_q    <= 15'd0;
      dout_q  <= 11'd0;
      corr_q  <= 1'b0;
      dvld_q  <= 1'b0;
      ovr_q   <= 1'b0;
      errc_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cw_q    <= cw_d;
      dout_q  <= dout_d;
      corr_q  <= corr_d;
      dvld_q  <= dvld_d;
      ovr_q   <= ovr_d;
      errc_q  <= errc_d;
    end
  end

  assign data_out   = dout_q;
  assign data_valid = dvld_q;
  assign corrected  = corr_q;
  assign err_count  = errc_q;
  assign overrun    = ovr_q;

endmodule
